// File: rtl/game_pkg.sv
// Shared types and constants for the game frame sequencer and its tick source.
package game_pkg;

  localparam int unsigned CLK_HZ_DEF  = 100_000_000;
  localparam int unsigned TICK_HZ_DEF = 100;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned FRAME_W     = 16;
  localparam int unsigned OVR_W       = 8;

  localparam int unsigned PH_INPUT    = 0;
  localparam int unsigned PH_PLAYER   = 1;
  localparam int unsigned PH_OBJECTS  = 2;
  localparam int unsigned PH_COLLIDE  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by CLK_HZ/TICK_HZ and emits a one-cycle enable pulse when the
// count sits at its terminal value; shared with the VGA/animation logic.
module tick_prescaler
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ = TICK_HZ_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = $clog2(DIV);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("tick_prescaler: CLK_HZ/TICK_HZ must be a whole number >= 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Tick is registered one step early so it lines up with count == DIV-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_W'(DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_W'(DIV - 2));
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/game_tick_scheduler.sv
// Frame sequencer: on each accepted game tick, runs the update phases in order
// with a start/done handshake, and tracks frames, overruns and phase timeouts.
module game_tick_scheduler
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ    = TICK_HZ_DEF,
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_pause,
  input  logic                  i_clr_err,
  input  logic [NUM_PHASES-1:0] i_phase_done,
  output logic                  o_tick,
  output logic [NUM_PHASES-1:0] o_phase_start,
  output logic                  o_busy,
  output logic [IDX_W-1:0]      o_cur_phase,
  output logic [FRAME_W-1:0]    o_frame_cnt,
  output logic [OVR_W-1:0]      o_overrun_cnt,
  output logic [NUM_PHASES-1:0] o_timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  if (NUM_PHASES < 1 || NUM_PHASES > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("game_tick_scheduler: NUM_PHASES must be 1..8 and TIMEOUT >= 1");
  end

  sched_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [TO_W-1:0]       r_tcnt, w_tcnt_nxt;
  logic                  w_tick, w_adv, w_timeout, w_last;
  logic [7:0]            w_done_ext, w_idx_mask, w_nxt_mask;

  logic                  r_busy;
  logic [IDX_W-1:0]      r_cur_phase;
  logic [NUM_PHASES-1:0] r_phase_start, r_timeout_err;
  logic [FRAME_W-1:0]    r_frame_cnt;
  logic [OVR_W-1:0]      r_overrun_cnt;

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .o_tick  (w_tick)
  );

  // Zero-extend to 8 lanes so a 3-bit index always selects in range.
  assign w_done_ext = 8'(i_phase_done);
  assign w_idx_mask = 8'(1) << r_idx;
  assign w_nxt_mask = 8'(1) << w_idx_nxt;
  assign w_last     = (r_idx == IDX_W'(NUM_PHASES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tcnt_nxt  = r_tcnt;
    w_adv       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick && !i_pause) begin
          w_state_nxt = ST_START;
          w_idx_nxt   = '0;
        end
      end
      ST_START: begin
        w_state_nxt = ST_WAIT;
        w_tcnt_nxt  = '0;
      end
      ST_WAIT: begin
        // Done beats timeout when both land in the same cycle.
        if (w_done_ext[r_idx]) begin
          w_adv = 1'b1;
        end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
          w_adv     = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TO_W'(1);
        end
        if (w_adv) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_START;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // Outputs are registered from next-state so they align with the FSM state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy        <= 1'b0;
      r_cur_phase   <= '0;
      r_phase_start <= '0;
      r_frame_cnt   <= '0;
      r_overrun_cnt <= '0;
      r_timeout_err <= '0;
    end else begin
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_cur_phase   <= (w_state_nxt == ST_IDLE) ? '0 : w_idx_nxt;
      r_phase_start <= (w_state_nxt == ST_START) ? NUM_PHASES'(w_nxt_mask) : '0;
      if (w_adv && w_last) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
      if (i_clr_err) begin
        r_overrun_cnt <= '0;
        r_timeout_err <= '0;
      end else begin
        if (w_tick && (r_state != ST_IDLE) && (r_overrun_cnt != '1)) begin
          r_overrun_cnt <= r_overrun_cnt + OVR_W'(1);
        end
        if (w_timeout) begin
          r_timeout_err <= r_timeout_err | NUM_PHASES'(w_idx_mask);
        end
      end
    end
  end

  assign o_tick        = w_tick;
  assign o_busy        = r_busy;
  assign o_cur_phase   = r_cur_phase;
  assign o_phase_start = r_phase_start;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_overrun_cnt = r_overrun_cnt;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler (DIV=10, 4 phases, TIMEOUT=8)
// using a schedule-based reference model and a responder driven from it.
module tb_game_tick_scheduler;

  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, pause, clr;
  logic [NP-1:0] done;
  logic          o_tick, o_busy;
  logic [NP-1:0] o_phase_start, o_timeout_err;
  logic [2:0]    o_cur_phase;
  logic [15:0]   o_frame_cnt;
  logic [7:0]    o_overrun_cnt;

  always #5 clk = ~clk;

  game_tick_scheduler #(
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .NUM_PHASES (NP),
    .TIMEOUT    (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_pause       (pause),
    .i_clr_err     (clr),
    .i_phase_done  (done),
    .o_tick        (o_tick),
    .o_phase_start (o_phase_start),
    .o_busy        (o_busy),
    .o_cur_phase   (o_cur_phase),
    .o_frame_cnt   (o_frame_cnt),
    .o_overrun_cnt (o_overrun_cnt),
    .o_timeout_err (o_timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: prescaler phase plus the planned schedule of the current phase.
  int       m_p, m_idx, m_start, m_dly, m_adv, m_frame, m_ovr;
  bit       m_busy, m_to;
  bit [3:0] m_terr;
  int       dly_cfg [NP];   // 0 = random delay; values > 8 mean the unit never answers
  bit       noise_on;

  task automatic model_reset();
    m_p = 0; m_busy = 0; m_idx = 0; m_frame = 0; m_ovr = 0; m_terr = '0;
    m_start = -100; m_adv = -100; m_dly = 0; m_to = 0;
  endtask

  task automatic plan(input int s, input int i);
    m_idx   = i;
    m_start = s;
    m_dly   = (dly_cfg[i] != 0) ? dly_cfg[i] : int'($urandom_range(1, 11));
    m_to    = (m_dly > 8);
    m_adv   = s + (m_to ? 8 : m_dly);
  endtask

  task automatic model_update();
    bit tk;
    tk  = (m_p == 9);
    m_p = en ? (m_p + 1) % 10 : 0;
    if (m_busy && tk && m_ovr < 255) m_ovr++;
    if (m_busy && cyc == m_adv) begin
      if (m_to) m_terr[m_idx] = 1'b1;
      if (m_idx == NP - 1) begin
        m_busy  = 0;
        m_frame = (m_frame + 1) & 16'hFFFF;
      end else begin
        plan(cyc + 1, m_idx + 1);
      end
    end else if (!m_busy && tk && !pause) begin
      m_busy = 1;
      plan(cyc + 1, 0);
    end
    if (clr) begin
      m_ovr  = 0;
      m_terr = '0;
    end
  endtask

  // One clock: responder drives done for this cycle, model advances on the edge.
  task automatic step();
    logic [3:0] d, own;
    own = 4'b0001 << m_idx;
    d   = noise_on ? 4'($urandom) : 4'b0000;
    if (m_busy) begin
      d = d & ~own;
      if (noise_on && cyc == m_start && $urandom_range(0, 1) == 1) d = d | own;
      if (!m_to && cyc == m_start + m_dly) d = d | own;
    end
    done = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    cyc++;
    #1;
  endtask

  task automatic wait_tick(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (o_tick === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_tick: no tick within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (o_busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic clear_errs();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pause = 1'b1; clr = 1'b0; done = '0; noise_on = 0;
    dly_cfg = '{2, 2, 2, 2};
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++;
      if ({o_tick, o_phase_start, o_busy, o_cur_phase, o_frame_cnt, o_overrun_cnt,
           o_timeout_err} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b ps=%b frame=%0d ovr=%0d terr=%b, want all 0",
                 o_busy, o_phase_start, o_frame_cnt, o_overrun_cnt, o_timeout_err);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_prescaler();
    bit exp;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp = (k % 10 == 9);
      checks++;
      if (o_tick !== exp) begin
        errors++;
        $display("FAIL tick_period: cycle %0d after release got %b want %b", k, o_tick, exp);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 26; k++) begin
      if (k == 6) en = 1'b1;
      step();
      exp = (m_p == 9);
      checks++;
      if (o_tick !== exp) begin
        errors++;
        $display("FAIL tick_enable: step %0d got %b want %b", k, o_tick, exp);
      end
    end
  endtask

  task automatic test_frame_basic();
    logic [3:0] exp_ps;
    int f0;
    dly_cfg = '{2, 2, 2, 2};
    f0 = m_frame;
    pause = 1'b0;
    wait_tick(12);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 1) pause = 1'b1;
      exp_ps = (k <= 10 && (k - 1) % 3 == 0) ? (4'b0001 << ((k - 1) / 3)) : 4'b0000;
      checks++;
      if (o_phase_start !== exp_ps || o_busy !== (k <= 12)) begin
        errors++;
        $display("FAIL frame_seq: k=%0d got ps=%b busy=%b want ps=%b busy=%b",
                 k, o_phase_start, o_busy, exp_ps, (k <= 12));
      end
      if (k <= 12) begin
        checks++;
        if (o_cur_phase !== 3'((k - 1) / 3)) begin
          errors++;
          $display("FAIL cur_phase: k=%0d got %0d want %0d", k, o_cur_phase, (k - 1) / 3);
        end
      end
    end
    checks++;
    if (o_frame_cnt !== 16'(f0 + 1)) begin
      errors++;
      $display("FAIL frame_cnt: got %0d want %0d", o_frame_cnt, f0 + 1);
    end
  endtask

  task automatic test_timeout();
    bit saw3;
    int f0;
    clear_errs();
    dly_cfg = '{2, 2, 99, 2};
    f0 = m_frame;
    saw3 = 0;
    pause = 1'b0;
    wait_tick(12);
    step();
    pause = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_phase_start[3] === 1'b1) saw3 = 1;
      checks++;
      if (o_timeout_err !== m_terr) begin
        errors++;
        $display("FAIL timeout_track: got %b want %b", o_timeout_err, m_terr);
      end
      if (o_busy === 1'b0) break;
    end
    checks++;
    if (o_timeout_err !== 4'b0100 || !saw3 || o_frame_cnt !== 16'(f0 + 1)) begin
      errors++;
      $display("FAIL timeout_frame: got terr=%b ph3=%b frame=%0d want terr=0100 ph3=1 frame=%0d",
               o_timeout_err, saw3, o_frame_cnt, f0 + 1);
    end
    clear_errs();
    checks++;
    if (o_timeout_err !== 4'b0000 || o_frame_cnt !== 16'(f0 + 1)) begin
      errors++;
      $display("FAIL clr_err: got terr=%b frame=%0d want terr=0000 frame=%0d",
               o_timeout_err, o_frame_cnt, f0 + 1);
    end
  endtask

  task automatic test_overrun();
    int restarts;
    clear_errs();
    dly_cfg = '{2, 99, 2, 2};
    restarts = 0;
    pause = 1'b0;
    wait_tick(12);
    step();
    pause = 1'b1;
    checks++;
    if (o_phase_start !== 4'b0001) begin
      errors++;
      $display("FAIL overrun_start: got ps=%b want 0001", o_phase_start);
    end
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_phase_start[0] === 1'b1) restarts++;
      if (o_busy === 1'b0) break;
    end
    checks++;
    if (o_overrun_cnt !== 8'd1 || restarts != 0) begin
      errors++;
      $display("FAIL overrun: got ovr=%0d restarts=%0d want ovr=1 restarts=0",
               o_overrun_cnt, restarts);
    end
  endtask

  task automatic test_pause();
    int nticks, mticks, ps_seen, o0;
    dly_cfg = '{2, 2, 2, 2};
    pause = 1'b1;
    o0 = m_ovr;
    nticks = 0; mticks = 0; ps_seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (o_tick === 1'b1) nticks++;
      if (m_p == 9) mticks++;
      if (o_phase_start !== 4'b0000 || o_busy !== 1'b0) ps_seen++;
    end
    checks++;
    if (ps_seen != 0 || nticks != mticks || nticks < 2 || o_overrun_cnt !== 8'(o0)) begin
      errors++;
      $display("FAIL pause_hold: got starts=%0d ticks=%0d ovr=%0d want 0, %0d, %0d",
               ps_seen, nticks, o_overrun_cnt, mticks, o0);
    end
    pause = 1'b0;
    wait_tick(12);
    step();
    pause = 1'b1;
    checks++;
    if (o_phase_start !== 4'b0001 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL pause_release: got ps=%b busy=%b want 0001 1", o_phase_start, o_busy);
    end
    wait_idle(40);
  endtask

  task automatic test_clr_priority();
    bit ok;
    clear_errs();
    dly_cfg = '{99, 99, 99, 99};
    pause = 1'b0;
    wait_tick(12);
    step();
    pause = 1'b1;
    ok = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_tick === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_tick: got tick=%b busy=%b want 1 1", ok, o_busy);
    end
    clear_errs();
    checks++;
    if (o_overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_vs_overrun: got ovr=%0d want 0", o_overrun_cnt);
    end
    ok = 0;
    for (int k = 0; k < 15; k++) begin
      if (m_busy && m_to && cyc == m_adv) begin
        ok = 1;
        break;
      end
      step();
    end
    clear_errs();
    checks++;
    if (!ok || o_timeout_err !== 4'b0000) begin
      errors++;
      $display("FAIL clr_vs_timeout: got reached=%b terr=%b want 1 0000", ok, o_timeout_err);
    end
    wait_idle(60);
    checks++;
    if (o_overrun_cnt !== 8'(m_ovr) || o_timeout_err !== m_terr) begin
      errors++;
      $display("FAIL clr_after: got ovr=%0d terr=%b want %0d %b",
               o_overrun_cnt, o_timeout_err, m_ovr, m_terr);
    end
  endtask

  task automatic test_saturate();
    clear_errs();
    dly_cfg = '{99, 99, 99, 99};
    pause = 1'b0;
    for (int k = 0; k < 3800; k++) begin
      step();
      if (k % 50 == 0) begin
        checks++;
        if (o_overrun_cnt !== 8'(m_ovr)) begin
          errors++;
          $display("FAIL overrun_track: got %0d want %0d", o_overrun_cnt, m_ovr);
        end
      end
    end
    checks++;
    if (o_overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL overrun_saturate: got %0d want 255", o_overrun_cnt);
    end
    pause = 1'b1;
    wait_idle(60);
    clear_errs();
  endtask

  task automatic test_random();
    logic [3:0] exp_ps;
    logic [2:0] exp_cur;
    dly_cfg = '{0, 0, 0, 0};
    noise_on = 1;
    for (int k = 0; k < 3000; k++) begin
      en    = ($urandom_range(0, 19) != 0);
      pause = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      step();
      exp_ps  = (m_busy && cyc == m_start) ? (4'b0001 << m_idx) : 4'b0000;
      exp_cur = m_busy ? 3'(m_idx) : 3'd0;
      checks++;
      if (o_tick !== (m_p == 9) || o_busy !== m_busy || o_phase_start !== exp_ps ||
          o_cur_phase !== exp_cur) begin
        errors++;
        $display("FAIL rand_ctrl: cyc=%0d got tick=%b busy=%b ps=%b cur=%0d want %b %b %b %0d",
                 cyc, o_tick, o_busy, o_phase_start, o_cur_phase, (m_p == 9), m_busy,
                 exp_ps, exp_cur);
      end
      checks++;
      if (o_frame_cnt !== 16'(m_frame) || o_overrun_cnt !== 8'(m_ovr) ||
          o_timeout_err !== m_terr) begin
        errors++;
        $display("FAIL rand_status: cyc=%0d got frame=%0d ovr=%0d terr=%b want %0d %0d %b",
                 cyc, o_frame_cnt, o_overrun_cnt, o_timeout_err, m_frame, m_ovr, m_terr);
      end
    end
    noise_on = 0; en = 1'b1; clr = 1'b0; pause = 1'b1;
    wait_idle(60);
  endtask

  task automatic test_async_reset();
    bit ok;
    int k9;
    dly_cfg = '{2, 2, 6, 2};
    pause = 1'b0;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (m_busy && m_idx == 2 && cyc > m_start) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok || o_cur_phase !== 3'd2 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL reach_wait2: got reached=%b cur=%0d busy=%b want 1 2 1",
               ok, o_cur_phase, o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (o_busy !== 1'b0 || o_phase_start !== 4'b0000 || o_cur_phase !== 3'd0 ||
        o_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b ps=%b cur=%0d frame=%0d want all 0",
               o_busy, o_phase_start, o_cur_phase, o_frame_cnt);
    end
    step();
    step();
    rst_n = 1'b1;
    k9 = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (o_tick === 1'b1) begin
        k9 = k;
        break;
      end
    end
    step();
    pause = 1'b1;
    checks++;
    if (k9 != 9 || o_phase_start !== 4'b0001 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_reset: got tick_at=%0d ps=%b busy=%b want 9 0001 1",
               k9, o_phase_start, o_busy);
    end
    wait_idle(40);
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_frame_basic();
    test_timeout();
    test_overrun();
    test_pause();
    test_clr_priority();
    test_saturate();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
